// File: rtl/adc_pipe_stage_emulator.sv
// Behavioural emulator of a pipelined ADC with 1-bit-redundant stages and a final flash stage.
// Each stage resolves one digit per cycle from its residue; comparator offsets come from ofs_i.
module adc_pipe_stage_emulator #(
    parameter int unsigned NUM_BITS           = 3,
    parameter int unsigned NUM_BITS_PER_STAGE = 2,
    parameter int unsigned REDUNDANCY         = 1,
    parameter int unsigned BITS_ADC_STAGE     = 1,
    parameter int unsigned VIN_BITS           = 8,
    localparam int unsigned NUM_STAGES =
        (NUM_BITS - BITS_ADC_STAGE) / (NUM_BITS_PER_STAGE - REDUNDANCY),
    localparam int unsigned G = 2 ** (NUM_BITS_PER_STAGE - 1)
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [VIN_BITS-1:0]                        vin_i,
    input  logic                                       vin_valid_i,
    input  logic [2*NUM_STAGES-1:0]                    ofs_i,
    output logic [NUM_BITS_PER_STAGE*NUM_STAGES-1:0]   d_stage_o,
    output logic [BITS_ADC_STAGE-1:0]                  d_last_stage_o,
    output logic [NUM_STAGES:0]                        stage_valid_o,
    output logic [NUM_BITS-1:0]                        code_o,
    output logic                                       code_valid_o
);

    localparam int unsigned NB = NUM_BITS_PER_STAGE;
    localparam int unsigned SW = VIN_BITS + NB + 4;
    // One LSB of the digit decision threshold scale (2^VIN_BITS at the 4*2^VIN_BITS scale).
    localparam logic signed [SW-1:0] OneV  = SW'(1) << VIN_BITS;
    localparam logic signed [SW-1:0] DMaxS = SW'(2 * G - 2);
    localparam logic [NB-1:0]        DMax  = NB'(2 * G - 2);

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [VIN_BITS-1:0] r_in;
        logic                v_in;
        logic [NUM_BITS-1:0] c_in;
        logic signed [SW-1:0] num;
        logic signed [SW-1:0] quo;
        logic [NB-1:0]       d_d;
        logic [VIN_BITS-1:0] res_d;
        logic [NB-1:0]       d_q;
        logic [VIN_BITS-1:0] res_q;
        logic [NUM_BITS-1:0] code_q;
        logic                vld_q;

        if (k == 0) begin : g_first
            assign r_in = vin_i;
            assign v_in = vin_valid_i;
            assign c_in = vin_i[VIN_BITS-1 -: NUM_BITS];
        end else begin : g_next
            assign r_in = g_stage[k-1].res_q;
            assign v_in = g_stage[k-1].vld_q;
            assign c_in = g_stage[k-1].code_q;
        end

        // d = clamp(floor(2G*r - 1/2 + s/4)), evaluated exactly at scale 4*2^VIN_BITS.
        always_comb begin
            num = $signed(SW'(r_in) << (NB + 2)) - (OneV <<< 1);
            case (ofs_i[2*k +: 2])
                2'b01:   num = num + OneV;
                2'b11:   num = num - OneV;
                default: num = num;
            endcase
            quo = num >>> (VIN_BITS + 2);
            if (quo[SW-1]) begin
                d_d = '0;
            end else if (quo > DMaxS) begin
                d_d = DMax;
            end else begin
                d_d = quo[NB-1:0];
            end
            res_d = VIN_BITS'((SW'(r_in) << (NB - 1)) - (SW'(d_d) << (VIN_BITS - 1)));
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                d_q    <= '0;
                res_q  <= '0;
                code_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= v_in;
                if (v_in) begin
                    d_q    <= d_d;
                    res_q  <= res_d;
                    code_q <= c_in;
                end
            end
        end

        assign d_stage_o[k*NB +: NB] = d_q;
        assign stage_valid_o[k]      = vld_q;
    end

    logic [BITS_ADC_STAGE-1:0] last_d;
    logic [BITS_ADC_STAGE-1:0] last_q;
    logic [NUM_BITS-1:0]       code_q;
    logic                      last_vld_q;

    assign last_d = BITS_ADC_STAGE'(g_stage[NUM_STAGES-1].res_q >> (VIN_BITS - BITS_ADC_STAGE));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q     <= '0;
            code_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_vld_q <= g_stage[NUM_STAGES-1].vld_q;
            if (g_stage[NUM_STAGES-1].vld_q) begin
                last_q <= last_d;
                code_q <= g_stage[NUM_STAGES-1].code_q;
            end
        end
    end

    assign d_last_stage_o            = last_q;
    assign stage_valid_o[NUM_STAGES] = last_vld_q;
    assign code_o                    = code_q;
    assign code_valid_o              = last_vld_q;

endmodule

// File: tb/tb_adc_pipe_stage_emulator.sv
// Self-checking bench: real-valued reference of the stage equations, directed scenarios,
// and a randomized loopback sweep through a digit-recombining encoder.
module tb_adc_pipe_stage_emulator;

    localparam int N   = 2;
    localparam int NB  = 2;
    localparam int BAS = 1;
    localparam real G  = 2.0;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic [7:0] vin_i = '0;
    logic       vin_valid_i = 1'b0;
    logic [3:0] ofs_i = '0;
    logic [3:0] d_stage_o;
    logic [0:0] d_last_stage_o;
    logic [2:0] stage_valid_o;
    logic [2:0] code_o;
    logic       code_valid_o;

    adc_pipe_stage_emulator dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .vin_i          (vin_i),
        .vin_valid_i    (vin_valid_i),
        .ofs_i          (ofs_i),
        .d_stage_o      (d_stage_o),
        .d_last_stage_o (d_last_stage_o),
        .stage_valid_o  (stage_valid_o),
        .code_o         (code_o),
        .code_valid_o   (code_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference state: what each stage's registers should hold, in real-valued terms.
    real m_r[N];
    int  m_d[N];
    int  m_c[N];
    bit  m_v[N];
    int  m_last, m_code;
    bit  m_vl;

    int  q_d0[$];
    int  q_d1[$];
    int  q_vin[$];

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_r[k] = 0.0; m_d[k] = 0; m_c[k] = 0; m_v[k] = 0;
        end
        m_last = 0; m_code = 0; m_vl = 0;
        q_d0.delete(); q_d1.delete(); q_vin.delete();
    endtask

    task automatic model_edge(input logic [7:0] vin, input logic vld, input logic [3:0] ofs);
        real r, x;
        int  s, dd, c;
        bit  v;
        m_vl = m_v[N-1];
        if (m_v[N-1]) begin
            m_last = $rtoi($floor(m_r[N-1] * (2.0 ** BAS)));
            m_code = m_c[N-1];
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (k == 0) begin
                v = vld; r = vin / 256.0; c = $rtoi($floor(r * 8.0));
            end else begin
                v = m_v[k-1]; r = m_r[k-1]; c = m_c[k-1];
            end
            if (v) begin
                case (ofs[2*k +: 2])
                    2'b01:   s = 1;
                    2'b11:   s = -1;
                    default: s = 0;
                endcase
                x  = $floor(2.0 * G * r - 0.5 + s / 4.0);
                dd = (x < 0.0) ? 0 : (x > 2.0 * G - 2.0) ? $rtoi(2.0 * G - 2.0) : $rtoi(x);
                m_d[k] = dd;
                m_r[k] = G * r - dd / 2.0;
                m_c[k] = c;
            end
            m_v[k] = v;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < N; k++) begin
            chk({tag, "_d"}, int'(d_stage_o[k*NB +: NB]), m_d[k]);
            chk({tag, "_sv"}, int'(stage_valid_o[k]), int'(m_v[k]));
        end
        chk({tag, "_last"}, int'(d_last_stage_o), m_last);
        chk({tag, "_svl"}, int'(stage_valid_o[N]), int'(m_vl));
        chk({tag, "_code"}, int'(code_o), m_code);
        chk({tag, "_cv"}, int'(code_valid_o), int'(m_vl));
    endtask

    // Recombines digits with weights 2,1 plus flash, aligned per sample via queues.
    task automatic encoder_step();
        int enc, exp;
        if (stage_valid_o[0]) q_d0.push_back(int'(d_stage_o[1:0]));
        if (stage_valid_o[1]) q_d1.push_back(int'(d_stage_o[3:2]));
        if (code_valid_o) begin
            if (q_d0.size() == 0 || q_d1.size() == 0 || q_vin.size() == 0) begin
                chk("enc_underflow", 1, 0);
            end else begin
                enc = 2 * q_d0.pop_front() + q_d1.pop_front() + int'(d_last_stage_o);
                exp = q_vin.pop_front() >> 5;
                chk("enc_sum", enc, exp);
                chk("enc_code", int'(code_o), exp);
            end
        end
    endtask

    // Called at a negedge: drive inputs, take one edge, check at the next negedge.
    task automatic step(input logic [7:0] vin, input logic vld, input logic [3:0] ofs);
        vin_i = vin; vin_valid_i = vld; ofs_i = ofs;
        @(posedge clk_i);
        model_edge(vin, vld, ofs);
        if (vld) q_vin.push_back(int'(vin));
        @(negedge clk_i);
        compare_all("step");
        encoder_step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_d"}, int'(d_stage_o), 0);
        chk({tag, "_last"}, int'(d_last_stage_o), 0);
        chk({tag, "_sv"}, int'(stage_valid_o), 0);
        chk({tag, "_code"}, int'(code_o), 0);
        chk({tag, "_cv"}, int'(code_valid_o), 0);
    endtask

    task automatic pulse_reset(input string tag);
        reset_i = 1'b1;
        #1;
        model_clear();
        check_zero(tag);
        @(negedge clk_i);
        check_zero({tag, "_held"});
        reset_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cv_exp[6];
        int cd_exp[6];
        model_clear();
        @(negedge clk_i);

        // Reset, then idle with no valid.
        pulse_reset("rst");
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b0, 4'h0);
            check_zero("rst_idle");
        end

        // Full-scale sample, accepted on the first edges after reset.
        pulse_reset("rst2");
        step(8'hFF, 1'b1, 4'h0);
        chk("fs_sv_n", int'(stage_valid_o), 3'b001);
        chk("fs_d0", int'(d_stage_o[1:0]), 2);
        step(8'h00, 1'b0, 4'h0);
        chk("fs_sv_n1", int'(stage_valid_o), 3'b010);
        chk("fs_d1", int'(d_stage_o[3:2]), 2);
        step(8'h00, 1'b0, 4'h0);
        chk("fs_sv_n2", int'(stage_valid_o), 3'b100);
        chk("fs_last", int'(d_last_stage_o), 1);
        chk("fs_code", int'(code_o), 7);
        step(8'h00, 1'b0, 4'h0);
        chk("fs_sv_after", int'(stage_valid_o), 0);

        // Offset redundancy: same sample, with and without a -1 offset on stage 0.
        step(8'h60, 1'b1, 4'h0);
        chk("red0_d0", int'(d_stage_o[1:0]), 1);
        step(8'h00, 1'b0, 4'h0);
        chk("red0_d1", int'(d_stage_o[3:2]), 0);
        step(8'h00, 1'b0, 4'h0);
        chk("red0_last", int'(d_last_stage_o), 1);
        chk("red0_code", int'(code_o), 3);
        step(8'h60, 1'b1, 4'b0011);
        chk("red1_d0", int'(d_stage_o[1:0]), 0);
        step(8'h00, 1'b0, 4'h0);
        chk("red1_d1", int'(d_stage_o[3:2]), 2);
        step(8'h00, 1'b0, 4'h0);
        chk("red1_last", int'(d_last_stage_o), 1);
        chk("red1_code", int'(code_o), 3);
        step(8'h00, 1'b0, 4'h0);

        // Bubbles: valid 1,1,0,1 -> code_valid 1,1,0,1 two cycles later.
        cv_exp = '{0, 0, 1, 1, 0, 1};
        cd_exp = '{-1, -1, 1, 2, -1, 4};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: step(8'h20, 1'b1, 4'h0);
                1: step(8'h40, 1'b1, 4'h0);
                3: step(8'h80, 1'b1, 4'h0);
                default: step(8'h00, 1'b0, 4'h0);
            endcase
            chk("bub_cv", int'(code_valid_o), cv_exp[i]);
            if (cv_exp[i] == 1) chk("bub_code", int'(code_o), cd_exp[i]);
        end

        // Reset one cycle after accepting a sample: nothing may emerge afterwards.
        step(8'hC3, 1'b1, 4'h0);
        pulse_reset("midrst");
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1'b0, 4'h0);
            chk("midrst_cv", int'(code_valid_o), 0);
            chk("midrst_sv", int'(stage_valid_o), 0);
        end

        // Loopback sweep with random offsets and random bubbles.
        for (int v = 0; v < 256; v++) begin
            while ($urandom_range(0, 3) == 0)
                step(8'($urandom), 1'b0, 4'($urandom));
            step(8'(v), 1'b1, 4'($urandom));
        end
        for (int i = 0; i < 4; i++) step(8'($urandom), 1'b0, 4'($urandom));
        chk("loop_drained", q_vin.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
